timer_controller: RTL

Sequencing controller for the 60-second timer. It replaces divided-clock chains with a single-clock design: an internal prescaler generates a one-cycle seconds enable, and a mod-60 BCD seconds count advances on that enable. A start/stop/clear state machine gates the count, and the block flags completion. It sits between the debounced, synchronized user controls and the seven-segment display decode.

---
 rtl/timer_pkg.sv | 14 +
 rtl/bcd_sec_counter.sv | 47 ++++
 rtl/timer_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the 60-second timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/bcd_sec_counter.sv
// Mod-60 BCD seconds counter with enable, sync clear and a count==59 flag.
module bcd_sec_counter
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [3:0] ones_o,
  output logic [2:0] tens_o,
  output logic       at59_o
);

  logic [3:0] ones_q, ones_d;
  logic [2:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr_i) begin
      ones_d = '0;
      tens_d = '0;
    end else if (en_i) begin
      if (ones_q == ONES_MAX) begin
        ones_d = '0;
        tens_d = (tens_q == TENS_MAX) ? 3'd0 : tens_q + 3'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;
  assign at59_o = (ones_q == ONES_MAX) && (tens_q == TENS_MAX);

endmodule

// File: rtl/timer_controller.sv
// Single-clock 60-second timer: prescaler tick enable, start/stop/clear FSM,
// rising-edge command detection and a mod-60 BCD seconds count.
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic       Clockin,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  output logic [3:0] SecOnes,
  output logic [2:0] SecTens,
  output logic       Tick,
  output logic       Running,
  output logic       Done
);

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             start_prev_q, stop_prev_q, clear_prev_q;
  logic             start_cmd, stop_cmd, clear_cmd;
  logic             cnt_en, cnt_clr, at59, terminal;

  // Previous values reset high so a level held across reset release is not a command.
  always_ff @(posedge Clockin or negedge Resetn) begin
    if (!Resetn) begin
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      start_prev_q <= Start;
      stop_prev_q  <= Stop;
      clear_prev_q <= Clear;
    end
  end

  assign start_cmd = Start & ~start_prev_q;
  assign stop_cmd  = Stop  & ~stop_prev_q;
  assign clear_cmd = Clear & ~clear_prev_q;
  assign terminal  = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (clear_cmd) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start_cmd) state_d = RUN;
        end
        RUN: begin
          if (terminal) begin
            presc_d = '0;
            tick_d  = 1'b1;
            // Reaching 59 completes the run; completion beats a coincident Stop.
            if (at59) state_d = DONE;
            else begin
              cnt_en = 1'b1;
              if (stop_cmd) state_d = PAUSE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (stop_cmd) state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_cmd) state_d = RUN;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clockin or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  bcd_sec_counter u_cnt (
    .clk_i  (Clockin),
    .rst_ni (Resetn),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .ones_o (SecOnes),
    .tens_o (SecTens),
    .at59_o (at59)
  );

  assign Tick    = tick_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == DONE);

endmodule
